// File: rtl/uart_rx_cmd_parser.sv
// Command-frame decoder behind the UART receiver: turns received bytes into
// register-file write/read pulses and ALU operation pulses, with an inter-byte timeout.
module uart_rx_cmd_parser #(
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned FUN_WIDTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic                  PAR_ERR,
  input  logic                  STP_ERR,
  output logic                  RF_WR_EN,
  output logic                  RF_RD_EN,
  output logic [ADDR_WIDTH-1:0] RF_ADDR,
  output logic [DATA_WIDTH-1:0] RF_WR_DATA,
  output logic                  ALU_EN,
  output logic [FUN_WIDTH-1:0]  ALU_FUN,
  output logic                  CMD_ERR,
  output logic                  BUSY
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast =
      CntW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    StIdle,
    StWrAddr,
    StWrData,
    StRdAddr,
    StAluA,
    StAluB,
    StAluFun,
    StNopFun
  } state_e;

  state_e                state;
  logic [CntW-1:0]       tmo_cnt;
  // Write address is staged here so RF_ADDR only moves together with RF_WR_EN.
  logic [ADDR_WIDTH-1:0] wr_addr;

  logic good_byte;
  logic bad_byte;

  assign good_byte = RX_D_VLD & ~PAR_ERR & ~STP_ERR;
  assign bad_byte  = RX_D_VLD & (PAR_ERR | STP_ERR);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= StIdle;
      tmo_cnt    <= '0;
      wr_addr    <= '0;
      RF_WR_EN   <= 1'b0;
      RF_RD_EN   <= 1'b0;
      RF_ADDR    <= '0;
      RF_WR_DATA <= '0;
      ALU_EN     <= 1'b0;
      ALU_FUN    <= '0;
      CMD_ERR    <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      RF_WR_EN <= 1'b0;
      RF_RD_EN <= 1'b0;
      ALU_EN   <= 1'b0;
      CMD_ERR  <= 1'b0;

      if (bad_byte) begin
        tmo_cnt <= '0;
        CMD_ERR <= 1'b1;
        state   <= StIdle;
        BUSY    <= 1'b0;
      end else if (good_byte) begin
        tmo_cnt <= '0;
        unique case (state)
          StIdle: begin
            case (RX_P_DATA)
              8'hAA: begin
                state <= StWrAddr;
                BUSY  <= 1'b1;
              end
              8'hBB: begin
                state <= StRdAddr;
                BUSY  <= 1'b1;
              end
              8'hCC: begin
                state <= StAluA;
                BUSY  <= 1'b1;
              end
              8'hDD: begin
                state <= StNopFun;
                BUSY  <= 1'b1;
              end
              default: CMD_ERR <= 1'b1;
            endcase
          end
          StWrAddr: begin
            wr_addr <= RX_P_DATA[ADDR_WIDTH-1:0];
            state   <= StWrData;
          end
          StWrData: begin
            RF_ADDR    <= wr_addr;
            RF_WR_DATA <= RX_P_DATA[DATA_WIDTH-1:0];
            RF_WR_EN   <= 1'b1;
            state      <= StIdle;
            BUSY       <= 1'b0;
          end
          StRdAddr: begin
            RF_ADDR  <= RX_P_DATA[ADDR_WIDTH-1:0];
            RF_RD_EN <= 1'b1;
            state    <= StIdle;
            BUSY     <= 1'b0;
          end
          StAluA: begin
            RF_ADDR    <= '0;
            RF_WR_DATA <= RX_P_DATA[DATA_WIDTH-1:0];
            RF_WR_EN   <= 1'b1;
            state      <= StAluB;
          end
          StAluB: begin
            RF_ADDR    <= ADDR_WIDTH'(1);
            RF_WR_DATA <= RX_P_DATA[DATA_WIDTH-1:0];
            RF_WR_EN   <= 1'b1;
            state      <= StAluFun;
          end
          StAluFun, StNopFun: begin
            ALU_FUN <= RX_P_DATA[FUN_WIDTH-1:0];
            ALU_EN  <= 1'b1;
            state   <= StIdle;
            BUSY    <= 1'b0;
          end
        endcase
      end else if (state == StIdle) begin
        tmo_cnt <= '0;
      end else if (TIMEOUT_CYCLES != 0 && tmo_cnt == CntLast) begin
        // Counter would reach TIMEOUT_CYCLES on this idle cycle: abandon the frame.
        tmo_cnt <= '0;
        CMD_ERR <= 1'b1;
        state   <= StIdle;
        BUSY    <= 1'b0;
      end else begin
        tmo_cnt <= tmo_cnt + CntW'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cmd_parser.sv
// Scoreboard bench for uart_rx_cmd_parser: a frame-level model predicts pulses,
// a negedge monitor compares every pulse and the held outputs each cycle.
module tb_uart_rx_cmd_parser;

  localparam int unsigned Tmo = 16;

  localparam int EvWr   = 0;
  localparam int EvRd   = 1;
  localparam int EvAlu  = 2;
  localparam int EvErr  = 3;
  localparam int EvNone = 15;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_vld;
  logic       par_err;
  logic       stp_err;
  logic       rf_wr_en;
  logic       rf_rd_en;
  logic [3:0] rf_addr;
  logic [7:0] rf_wr_data;
  logic       alu_en;
  logic [3:0] alu_fun;
  logic       cmd_err;
  logic       busy;

  uart_rx_cmd_parser #(
    .ADDR_WIDTH    (4),
    .DATA_WIDTH    (8),
    .FUN_WIDTH     (4),
    .TIMEOUT_CYCLES(Tmo)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .RX_P_DATA (rx_data),
    .RX_D_VLD  (rx_vld),
    .PAR_ERR   (par_err),
    .STP_ERR   (stp_err),
    .RF_WR_EN  (rf_wr_en),
    .RF_RD_EN  (rf_rd_en),
    .RF_ADDR   (rf_addr),
    .RF_WR_DATA(rf_wr_data),
    .ALU_EN    (alu_en),
    .ALU_FUN   (alu_fun),
    .CMD_ERR   (cmd_err),
    .BUSY      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         kind;
    logic [3:0] addr;
    logic [7:0] data;
    logic [3:0] fun;
    int         cyc;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] frame[$];
  int         cycle;
  int         idle_cnt;
  logic       exp_busy;
  logic [3:0] h_addr;
  logic [7:0] h_data;
  logic [3:0] h_fun;
  int         checks;
  int         passes;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
  endtask

  task automatic push_ev(input int k, input logic [3:0] a, input logic [7:0] d,
                         input logic [3:0] f);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    e.fun  = f;
    e.cyc  = cycle;
    exp_q.push_back(e);
    if (k == EvWr) begin
      h_addr = a;
      h_data = d;
    end
    if (k == EvRd) h_addr = a;
    if (k == EvAlu) h_fun = f;
  endtask

  // Frame-level reference: look at the collected bytes and decide what the frame implies.
  task automatic frame_rules();
    logic [7:0] cmd;
    int         n;
    cmd = frame[0];
    n   = frame.size();
    case (cmd)
      8'hAA: if (n == 3) begin
        push_ev(EvWr, frame[1][3:0], frame[2], 4'h0);
        frame.delete();
      end
      8'hBB: if (n == 2) begin
        push_ev(EvRd, frame[1][3:0], 8'h00, 4'h0);
        frame.delete();
      end
      8'hCC: begin
        if (n == 2) push_ev(EvWr, 4'h0, frame[1], 4'h0);
        if (n == 3) push_ev(EvWr, 4'h1, frame[2], 4'h0);
        if (n == 4) begin
          push_ev(EvAlu, 4'h0, 8'h00, frame[3][3:0]);
          frame.delete();
        end
      end
      8'hDD: if (n == 2) begin
        push_ev(EvAlu, 4'h0, 8'h00, frame[1][3:0]);
        frame.delete();
      end
      default: begin
        push_ev(EvErr, 4'h0, 8'h00, 4'h0);
        frame.delete();
      end
    endcase
  endtask

  task automatic model_step();
    if (rst) begin
      frame.delete();
      idle_cnt = 0;
      h_addr   = '0;
      h_data   = '0;
      h_fun    = '0;
    end else if (rx_vld) begin
      idle_cnt = 0;
      if (par_err || stp_err) begin
        push_ev(EvErr, 4'h0, 8'h00, 4'h0);
        frame.delete();
      end else begin
        frame.push_back(rx_data);
        frame_rules();
      end
    end else if (frame.size() > 0) begin
      idle_cnt++;
      if (idle_cnt == Tmo) begin
        push_ev(EvErr, 4'h0, 8'h00, 4'h0);
        frame.delete();
        idle_cnt = 0;
      end
    end else begin
      idle_cnt = 0;
    end
    exp_busy = (frame.size() > 0);
  endtask

  initial begin
    cycle    = 0;
    idle_cnt = 0;
    exp_busy = 1'b0;
    h_addr   = '0;
    h_data   = '0;
    h_fun    = '0;
    forever begin
      @(posedge clk);
      cycle++;
      model_step();
    end
  end

  // Monitor: sampled half a cycle after each active edge.
  initial begin
    forever begin
      int   npulse;
      int   act_kind;
      ev_t  e;
      @(negedge clk);
      npulse   = int'(rf_wr_en) + int'(rf_rd_en) + int'(alu_en) + int'(cmd_err);
      act_kind = rf_wr_en ? EvWr : rf_rd_en ? EvRd : alu_en ? EvAlu : cmd_err ? EvErr : EvNone;
      if (npulse > 0) chk("single_pulse", (npulse > 1), 0);
      if (exp_q.size() > 0 && exp_q[0].cyc == cycle) begin
        e = exp_q.pop_front();
        chk("pulse_kind", act_kind, e.kind);
      end else if (npulse > 0) begin
        chk("unexpected_pulse", act_kind, EvNone);
      end
      chk("busy", busy, exp_busy);
      chk("rf_addr", rf_addr, h_addr);
      chk("rf_wr_data", rf_wr_data, h_data);
      chk("alu_fun", alu_fun, h_fun);
    end
  end

  task automatic cyc(input logic v, input logic [7:0] d, input logic pe, input logic se,
                     input logic r);
    @(negedge clk);
    rx_vld  = v;
    rx_data = d;
    par_err = pe;
    stp_err = se;
    rst     = r;
  endtask

  task automatic send(input logic [7:0] d);
    cyc(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst     = 1'b1;
    rx_vld  = 1'b0;
    rx_data = 8'h00;
    par_err = 1'b0;
    stp_err = 1'b0;
    checks  = 0;
    passes  = 0;
    repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(2);

    // Write, read, ALU with operands
    send(8'hAA); send(8'h05); send(8'h3C); idle(2);
    send(8'hBB); send(8'h0F); idle(2);
    send(8'hCC); send(8'h12); send(8'h34); send(8'h03); idle(2);
    // Unknown command, parity error mid-frame, then operand-less ALU
    send(8'h55); idle(2);
    send(8'hAA); send(8'h02); cyc(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0); idle(1);
    send(8'hDD); send(8'h07); idle(2);
    send(8'hBB); cyc(1'b1, 8'h04, 1'b0, 1'b1, 1'b0); idle(2);
    // Timeout after silence, and a byte landing exactly on the expiry cycle
    send(8'hAA); idle(Tmo); idle(3);
    send(8'hAA); idle(Tmo - 1); send(8'h09); idle(Tmo - 1); send(8'h5A); idle(2);
    // Reset mid-frame, normal write afterwards, back-to-back strobes
    send(8'hAA); send(8'h05); cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1); idle(2);
    send(8'hAA); send(8'h01); send(8'hFF);
    send(8'hDD); send(8'h0A); idle(3);

    for (int f = 0; f < 250; f++) begin
      logic [7:0] cmd;
      int         len;
      case ($urandom_range(0, 9))
        0, 1:    cmd = 8'hAA;
        2, 3:    cmd = 8'hBB;
        4, 5:    cmd = 8'hCC;
        6, 7:    cmd = 8'hDD;
        default: cmd = 8'($urandom);
      endcase
      len = (cmd == 8'hAA) ? 3 : (cmd == 8'hCC) ? 4 :
            (cmd == 8'hBB || cmd == 8'hDD) ? 2 : 1;
      for (int b = 0; b < len; b++) begin
        logic [7:0] d;
        logic       pe;
        int         gap;
        gap = ($urandom_range(0, 9) == 0) ? $urandom_range(Tmo - 2, Tmo + 1) :
                                            $urandom_range(0, 2);
        idle(gap);
        if ($urandom_range(0, 60) == 0) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        d = (b == 0) ? cmd : 8'($urandom);
        if ($urandom_range(0, 19) == 0) begin
          pe = 1'($urandom_range(0, 1));
          cyc(1'b1, d, pe, ~pe | 1'($urandom_range(0, 1)), 1'b0);
        end else begin
          send(d);
        end
      end
    end
    idle(Tmo + 4);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
